// File: rtl/wb_arb_pkg.sv
// Shared encodings and sizing helper for the two-requester Wishbone arbiter.
// Imported by the grant logic and the arbiter top.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } gnt_idx_t;

    // Width of a counter that must reach TIMEOUT-1; never narrower than one bit.
    function automatic int tmo_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant decision, purely combinational.
// A lone request always wins; a tie goes to the requester named by prio.
module rr_grant2
    import wb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_idx_t   prio,
    output logic       gnt_valid,
    output gnt_idx_t   gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = M0;
        if (req == 2'b11) begin
            gnt_idx = prio;
        end else if (req[1]) begin
            gnt_idx = M1;
        end
    end

endmodule

// File: rtl/wb_arb2_rr.sv
// Round-robin arbiter letting two pipelined Wishbone requesters share one
// register-bank slave, one outstanding transaction at a time, with a timeout.
module wb_arb2_rr
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [31:0]       m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_stall_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [31:0]       m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_stall_o,

    output logic [31:0]       m_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [3:0]        s_sel_o,
    output logic [31:0]       s_dat_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_stall_i,
    input  logic [31:0]       s_dat_i
);

    localparam int                CNT_W    = tmo_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    gnt_idx_t          prio;
    gnt_idx_t          gnt;
    logic [CNT_W-1:0]  tmo_cnt;

    logic [1:0]        req;
    logic              gnt_valid;
    gnt_idx_t          gnt_idx;
    logic              accept;
    logic              gnt_cyc;

    logic              nxt_we;
    logic [ADDR_W-1:0] nxt_adr;
    logic [3:0]        nxt_sel;
    logic [31:0]       nxt_dat;

    logic              abort;
    logic              rsp_err;
    logic              rsp_ack;
    logic              tmo_hit;

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    rr_grant2 u_grant (
        .req       (req),
        .prio      (prio),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign accept = (state == IDLE) && gnt_valid;

    // Only the winner sees stall low, and only on its accept cycle; held in reset.
    assign m0_stall_o = req[0] & ~(rst_n_i & accept & (gnt_idx == M0));
    assign m1_stall_o = req[1] & ~(rst_n_i & accept & (gnt_idx == M1));

    assign nxt_we  = (gnt_idx == M1) ? m1_we_i  : m0_we_i;
    assign nxt_adr = (gnt_idx == M1) ? m1_adr_i : m0_adr_i;
    assign nxt_sel = (gnt_idx == M1) ? m1_sel_i : m0_sel_i;
    assign nxt_dat = (gnt_idx == M1) ? m1_dat_i : m0_dat_i;

    assign gnt_cyc = (gnt == M1) ? m1_cyc_i : m0_cyc_i;

    // Ending conditions while BUSY, strongest first: owner abandons the cycle,
    // slave error (beats a simultaneous ack), slave ack, then timeout.
    assign abort   = (state == BUSY) && !gnt_cyc;
    assign rsp_err = (state == BUSY) && gnt_cyc && s_err_i;
    assign rsp_ack = (state == BUSY) && gnt_cyc && !s_err_i && s_ack_i;
    assign tmo_hit = (state == BUSY) && gnt_cyc && !s_err_i && !s_ack_i
                     && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            prio     <= M0;
            gnt      <= M0;
            tmo_cnt  <= '0;
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;
            m_dat_o  <= '0;
            s_cyc_o  <= 1'b0;
            s_stb_o  <= 1'b0;
            s_we_o   <= 1'b0;
            s_adr_o  <= '0;
            s_sel_o  <= '0;
            s_dat_o  <= '0;
        end else begin
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        gnt     <= gnt_idx;
                        prio    <= (gnt_idx == M0) ? M1 : M0;
                        s_we_o  <= nxt_we;
                        s_adr_o <= nxt_adr;
                        s_sel_o <= nxt_sel;
                        s_dat_o <= nxt_dat;
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= BUSY;
                    end
                end

                BUSY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (!s_stall_i) begin
                        s_stb_o <= 1'b0;
                    end

                    if (abort) begin
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        state   <= IDLE;
                    end else if (rsp_err || rsp_ack) begin
                        m_dat_o  <= s_dat_i;
                        m0_ack_o <= rsp_ack && (gnt == M0);
                        m1_ack_o <= rsp_ack && (gnt == M1);
                        m0_err_o <= rsp_err && (gnt == M0);
                        m1_err_o <= rsp_err && (gnt == M1);
                        s_cyc_o  <= 1'b0;
                        s_stb_o  <= 1'b0;
                        state    <= IDLE;
                    end else if (tmo_hit) begin
                        m0_err_o <= (gnt == M0);
                        m1_err_o <= (gnt == M1);
                        s_cyc_o  <= 1'b0;
                        s_stb_o  <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Directed testbench for wb_arb2_rr: a transaction-level reference model is
// compared against the DUT every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_wb_arb2_rr;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;

    logic              m0_cyc_i, m0_stb_i, m0_we_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [3:0]        m0_sel_i;
    logic [31:0]       m0_dat_i;
    logic              m0_ack_o, m0_err_o, m0_stall_o;

    logic              m1_cyc_i, m1_stb_i, m1_we_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [3:0]        m1_sel_i;
    logic [31:0]       m1_dat_i;
    logic              m1_ack_o, m1_err_o, m1_stall_o;

    logic [31:0]       m_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [ADDR_W-1:0] s_adr_o;
    logic [3:0]        s_sel_o;
    logic [31:0]       s_dat_o;
    logic              s_ack_i, s_err_i, s_stall_i;
    logic [31:0]       s_dat_i;

    int checks;
    int errors;
    int grant_log[$];

    always #5 clk = ~clk;

    wb_arb2_rr #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
        .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .s_dat_i(s_dat_i)
    );

    // Reference model: one transaction in flight, tracked by owner and age.
    logic              req0, req1;
    int                winner;
    bit                mdl_busy, mdl_stb;
    int                mdl_owner, mdl_prio, mdl_age;
    bit   [1:0]        mdl_ack, mdl_err;
    logic [31:0]       mdl_dat;
    logic [ADDR_W-1:0] mdl_adr;
    logic [3:0]        mdl_sel;
    logic              mdl_we;
    logic [31:0]       mdl_wdat;
    logic              exp_stall0, exp_stall1;
    logic              owner_cyc;

    function automatic int pick(input logic r0, input logic r1, input int prio);
        if (r0 && r1) return prio;
        if (r1) return 1;
        return 0;
    endfunction

    always_comb begin
        req0       = m0_cyc_i & m0_stb_i;
        req1       = m1_cyc_i & m1_stb_i;
        winner     = pick(req0, req1, mdl_prio);
        exp_stall0 = req0 & ~(rst_n & ~mdl_busy & (winner == 0));
        exp_stall1 = req1 & ~(rst_n & ~mdl_busy & (winner == 1));
        owner_cyc  = (mdl_owner == 1) ? m1_cyc_i : m0_cyc_i;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy <= 0; mdl_stb <= 0; mdl_owner <= 0; mdl_prio <= 0; mdl_age <= 0;
            mdl_ack  <= '0; mdl_err <= '0; mdl_dat <= '0;
            mdl_adr  <= '0; mdl_sel <= '0; mdl_we <= 1'b0; mdl_wdat <= '0;
        end else begin
            mdl_ack <= '0;
            mdl_err <= '0;
            if (!mdl_busy) begin
                if (req0 || req1) begin
                    mdl_owner <= winner;
                    mdl_prio  <= 1 - winner;
                    mdl_busy  <= 1;
                    mdl_stb   <= 1;
                    mdl_age   <= 1;
                    mdl_adr   <= (winner == 1) ? m1_adr_i : m0_adr_i;
                    mdl_sel   <= (winner == 1) ? m1_sel_i : m0_sel_i;
                    mdl_we    <= (winner == 1) ? m1_we_i  : m0_we_i;
                    mdl_wdat  <= (winner == 1) ? m1_dat_i : m0_dat_i;
                end
            end else begin
                mdl_age <= mdl_age + 1;
                if (!s_stall_i) mdl_stb <= 0;
                if (!owner_cyc) begin
                    mdl_busy <= 0; mdl_stb <= 0;
                end else if (s_err_i || s_ack_i) begin
                    mdl_busy <= 0; mdl_stb <= 0;
                    mdl_dat  <= s_dat_i;
                    if (s_err_i) mdl_err[mdl_owner] <= 1'b1;
                    else         mdl_ack[mdl_owner] <= 1'b1;
                end else if (mdl_age >= TIMEOUT) begin
                    mdl_busy <= 0; mdl_stb <= 0;
                    mdl_err[mdl_owner] <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        checkOutput("cmp_m0_stall", m0_stall_o, exp_stall0);
        checkOutput("cmp_m1_stall", m1_stall_o, exp_stall1);
        checkOutput("cmp_ack", {m1_ack_o, m0_ack_o}, mdl_ack);
        checkOutput("cmp_err", {m1_err_o, m0_err_o}, mdl_err);
        checkOutput("cmp_s_cyc", s_cyc_o, mdl_busy);
        checkOutput("cmp_s_stb", s_stb_o, mdl_stb);
        if (mdl_busy) begin
            checkOutput("cmp_s_adr", s_adr_o, mdl_adr);
            checkOutput("cmp_s_sel", s_sel_o, mdl_sel);
            checkOutput("cmp_s_we",  s_we_o,  mdl_we);
            checkOutput("cmp_s_dat", s_dat_o, mdl_wdat);
        end
        if (mdl_ack != 0) checkOutput("cmp_m_dat", m_dat_o, mdl_dat);
        if (rst_n && req0 && !m0_stall_o) grant_log.push_back(0);
        if (rst_n && req1 && !m1_stall_o) grant_log.push_back(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [ADDR_W-1:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_adr_i = adr; m0_sel_i = sel; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_adr_i = adr; m1_sel_i = sel; m1_dat_i = dat;
        end
    endtask

    task automatic setSlave(input logic ack, input logic err, input logic stall, input logic [31:0] dat);
        s_ack_i = ack; s_err_i = err; s_stall_i = stall; s_dat_i = dat;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        bit found;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(0, 1, 1, 0, 8'h00, 4'hF, 32'h0);
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        setSlave(0, 0, 0, 32'h0);

        // Reset: outputs cleared, active request sees stall
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_m0_stall", m0_stall_o, 1);
        checkOutput("rst_s_cyc", s_cyc_o, 0);
        checkOutput("rst_m0_ack", m0_ack_o, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single write from m0, slave acks two cycles after strobe
        applyStimulus(0, 1, 1, 1, 8'h00, 4'hF, 32'h0000_0A52);
        #1;
        checkOutput("t1_accept_stall", m0_stall_o, 0);
        tick();
        checkOutput("t1_s_cyc", s_cyc_o, 1);
        checkOutput("t1_s_stb", s_stb_o, 1);
        checkOutput("t1_s_adr", s_adr_o, 8'h00);
        checkOutput("t1_s_dat", s_dat_o, 32'h0000_0A52);
        checkOutput("t1_s_sel", s_sel_o, 4'hF);
        checkOutput("t1_s_we", s_we_o, 1);
        applyStimulus(0, 1, 0, 1, 8'h00, 4'hF, 32'h0000_0A52);
        tick();
        checkOutput("t1_stb_drop", s_stb_o, 0);
        tick();
        setSlave(1, 0, 0, 32'h0);
        tick();
        checkOutput("t1_m0_ack", m0_ack_o, 1);
        checkOutput("t1_m1_ack", m1_ack_o, 0);
        checkOutput("t1_s_cyc_low", s_cyc_o, 0);
        setSlave(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        tick();
        checkOutput("t1_ack_once", m0_ack_o, 0);

        // Simultaneous reads right after reset: m0 first, m1 on the response cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 1, 1, 0, 8'h10, 4'hF, 32'h0);
        applyStimulus(1, 1, 1, 0, 8'h20, 4'hF, 32'h0);
        #1;
        checkOutput("t2_m0_stall", m0_stall_o, 0);
        checkOutput("t2_m1_stall", m1_stall_o, 1);
        tick();
        checkOutput("t2_s_adr0", s_adr_o, 8'h10);
        checkOutput("t2_m1_stall_busy", m1_stall_o, 1);
        applyStimulus(0, 1, 0, 0, 8'h10, 4'hF, 32'h0);
        setSlave(1, 0, 0, 32'h11);
        tick();
        checkOutput("t2_m0_ack", m0_ack_o, 1);
        checkOutput("t2_m_dat0", m_dat_o, 32'h11);
        setSlave(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        #1;
        checkOutput("t2_m1_accept", m1_stall_o, 0);
        tick();
        checkOutput("t2_s_adr1", s_adr_o, 8'h20);
        applyStimulus(1, 1, 0, 0, 8'h20, 4'hF, 32'h0);
        setSlave(1, 0, 0, 32'h22);
        tick();
        checkOutput("t2_m1_ack", m1_ack_o, 1);
        checkOutput("t2_m_dat1", m_dat_o, 32'h22);
        checkOutput("t2_m0_quiet", m0_ack_o, 0);
        setSlave(0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        tick();

        // Both requesting continuously: grants must alternate
        grant_log.delete();
        setSlave(1, 0, 0, 32'h0000_C0DE);
        applyStimulus(0, 1, 1, 1, 8'h30, 4'h3, 32'h1234);
        applyStimulus(1, 1, 1, 1, 8'h40, 4'hC, 32'h5678);
        for (int i = 0; i < 40 && grant_log.size() < 6; i++) @(posedge clk);
        #2;
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        setSlave(0, 0, 0, 32'h0);
        checkOutput("t3_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size())
                checkOutput($sformatf("t3_grant%0d", i), grant_log[i], i % 2);
        end
        tick();

        // Slave never responds: error after TIMEOUT busy cycles
        applyStimulus(0, 1, 1, 0, 8'h50, 4'hF, 32'h0);
        tick();
        applyStimulus(0, 1, 0, 0, 8'h50, 4'hF, 32'h0);
        k = 0;
        found = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            tick();
            if (m0_err_o) begin
                found = 1;
                k = i;
            end
        end
        checkOutput("t4_timeout_delay", k, 4);
        checkOutput("t4_s_cyc_low", s_cyc_o, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        applyStimulus(1, 1, 1, 1, 8'h60, 4'h1, 32'h0000_BEEF);
        #1;
        checkOutput("t4_next_accept", m1_stall_o, 0);
        tick();
        applyStimulus(1, 1, 0, 1, 8'h60, 4'h1, 32'h0000_BEEF);
        setSlave(1, 0, 0, 32'h0);
        tick();
        checkOutput("t4_next_ack", m1_ack_o, 1);
        setSlave(0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        tick();

        // ack and err together: err only; then a stray ack while idle
        applyStimulus(0, 1, 1, 0, 8'h70, 4'hF, 32'h0);
        tick();
        applyStimulus(0, 1, 0, 0, 8'h70, 4'hF, 32'h0);
        setSlave(1, 1, 0, 32'hDEAD);
        tick();
        checkOutput("t5_err", m0_err_o, 1);
        checkOutput("t5_no_ack", m0_ack_o, 0);
        setSlave(1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        tick();
        checkOutput("t5_late_ack0", {m1_ack_o, m0_ack_o}, 2'b00);
        tick();
        checkOutput("t5_late_ack1", {m1_ack_o, m0_ack_o}, 2'b00);
        setSlave(0, 0, 0, 32'h0);

        // Reset mid-transaction, then m0 must win a tie again
        applyStimulus(0, 1, 1, 1, 8'h80, 4'hF, 32'h77);
        tick();
        applyStimulus(0, 1, 0, 1, 8'h80, 4'hF, 32'h77);
        setSlave(0, 0, 1, 32'h0);
        tick();
        checkOutput("t6_busy_cyc", s_cyc_o, 1);
        checkOutput("t6_stalled_stb", s_stb_o, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_cyc", s_cyc_o, 0);
        checkOutput("t6_rst_stb", s_stb_o, 0);
        checkOutput("t6_rst_resp", {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}, 4'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        setSlave(0, 0, 0, 32'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 1, 1, 0, 8'h90, 4'hF, 32'h0);
        applyStimulus(1, 1, 1, 0, 8'hA0, 4'hF, 32'h0);
        #1;
        checkOutput("t6_m0_prio", m0_stall_o, 0);
        checkOutput("t6_m1_wait", m1_stall_o, 1);
        tick();
        checkOutput("t6_s_adr", s_adr_o, 8'h90);
        applyStimulus(0, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 8'h00, 4'h0, 32'h0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
